gray_rx_decoder: RTL

- Downstream consumer of the 3-bit Gray counter output.
- Synchronizes a Gray-coded count into the local clock domain and converts it to binary.
- Classifies each change as an up step, down step, or illegal skip, and keeps an extended signed-free position accumulator.
- Used wherever a Gray count crosses a clock domain, e.g. a pointer or encoder position.

---
 rtl/gray_rx_decoder.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/gray_rx_decoder.sv
// Gray-count receiver: synchronizes gray_in, decodes to binary, classifies up/down/illegal steps.
// Optional macro GRAY_RX_GLITCH_FILTER_EN: accept a value only after two equal consecutive samples.
module gray_rx_decoder #(
  parameter int W           = 3,
  parameter int SYNC_STAGES = 2,
  parameter int POS_W       = 8
) (
  input  logic             ck,
  input  logic             res,
  input  logic [W-1:0]     gray_in,
  input  logic             clr,
  output logic [W-1:0]     bin,
  output logic [POS_W-1:0] pos,
  output logic             up,
  output logic             dn,
  output logic             err,
  output logic             err_flag
);

  localparam logic [W-1:0]     ZERO_C     = {W{1'b0}};
  localparam logic [W-1:0]     STEP_UP_C  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]     STEP_DN_C  = {W{1'b1}};
  localparam logic [POS_W-1:0] POS_ZERO_C = {POS_W{1'b0}};
  localparam logic [POS_W-1:0] POS_ONE_C  = {{(POS_W-1){1'b0}}, 1'b1};

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [W-1:0]     sync_r [SYNC_STAGES];
  logic [W-1:0]     s_s;
  logic [W-1:0]     n_s;
  logic [W-1:0]     diff_s;
  logic             stable_s;
  logic [W-1:0]     bin_r, bin_nxt_s;
  logic [POS_W-1:0] pos_r, pos_nxt_s;
  logic             primed_r, primed_nxt_s;
  logic             up_r, up_nxt_s;
  logic             dn_r, dn_nxt_s;
  logic             err_r, err_nxt_s;
  logic             err_flag_r, err_flag_nxt_s;

  assign s_s    = sync_r[SYNC_STAGES-1];
  assign n_s    = gray2bin(s_s);
  assign diff_s = n_s - bin_r;

  // Synchronizer chain for the asynchronous Gray input
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_r[i] <= ZERO_C;
      end
    end else begin
      sync_r[0] <= gray_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_r[i] <= sync_r[i-1];
      end
    end
  end

`ifdef GRAY_RX_GLITCH_FILTER_EN
  logic [W-1:0] cand_r;

  // Candidate register: previous synchronized sample for the stability test
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      cand_r <= ZERO_C;
    end else begin
      cand_r <= s_s;
    end
  end

  assign stable_s = (s_s == cand_r);
`else
  assign stable_s = 1'b1;
`endif

  // Step classification and next-state for position and sticky error
  always_comb begin
    bin_nxt_s      = bin_r;
    primed_nxt_s   = primed_r;
    up_nxt_s       = 1'b0;
    dn_nxt_s       = 1'b0;
    err_nxt_s      = 1'b0;
    pos_nxt_s      = pos_r;
    err_flag_nxt_s = err_flag_r;

    if (!stable_s) begin
      bin_nxt_s = bin_r;
    end else if (!primed_r) begin
      primed_nxt_s = 1'b1;
      bin_nxt_s    = n_s;
    end else begin
      case (diff_s)
        ZERO_C: begin
          bin_nxt_s = bin_r;
        end
        STEP_UP_C: begin
          up_nxt_s  = 1'b1;
          bin_nxt_s = n_s;
        end
        STEP_DN_C: begin
          dn_nxt_s  = 1'b1;
          bin_nxt_s = n_s;
        end
        default: begin
          err_nxt_s = 1'b1;
          bin_nxt_s = n_s;
        end
      endcase
    end

    // clr overrides any position update and any new error in the same cycle
    if (clr) begin
      pos_nxt_s      = POS_ZERO_C;
      err_flag_nxt_s = 1'b0;
    end else if (up_nxt_s) begin
      pos_nxt_s      = pos_r + POS_ONE_C;
      err_flag_nxt_s = err_flag_r;
    end else if (dn_nxt_s) begin
      pos_nxt_s      = pos_r - POS_ONE_C;
      err_flag_nxt_s = err_flag_r;
    end else if (err_nxt_s) begin
      pos_nxt_s      = pos_r;
      err_flag_nxt_s = 1'b1;
    end else begin
      pos_nxt_s      = pos_r;
      err_flag_nxt_s = err_flag_r;
    end
  end

  // Decoder state and registered outputs
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      bin_r      <= ZERO_C;
      pos_r      <= POS_ZERO_C;
      primed_r   <= 1'b0;
      up_r       <= 1'b0;
      dn_r       <= 1'b0;
      err_r      <= 1'b0;
      err_flag_r <= 1'b0;
    end else begin
      bin_r      <= bin_nxt_s;
      pos_r      <= pos_nxt_s;
      primed_r   <= primed_nxt_s;
      up_r       <= up_nxt_s;
      dn_r       <= dn_nxt_s;
      err_r      <= err_nxt_s;
      err_flag_r <= err_flag_nxt_s;
    end
  end

  assign bin      = bin_r;
  assign pos      = pos_r;
  assign up       = up_r;
  assign dn       = dn_r;
  assign err      = err_r;
  assign err_flag = err_flag_r;

endmodule
